// File: rtl/comm_pkg.sv
// Shared definitions for the memory commutator RAM-port arbiter.
//   state_e       : arbiter FSM state encoding (value doubles as the grant code)
//   GNT_*         : grant_o codes
//   TIMEOUT_DATA  : read data returned to a requester whose access was aborted by the watchdog
package comm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_GNT_CPU = 2'b01,
        ST_GNT_DMA = 2'b10
    } state_e;

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_CPU  = 2'b01;
    localparam logic [1:0] GNT_DMA  = 2'b10;

    localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/comm_arb_wdog.sv
// Grant watchdog for comm_ram_arbiter (only built when COMM_ARB_TIMEOUT_EN is defined).
// Counts granted cycles that pass without a RAM ack and pulses expire on the cycle the
// count reaches TIMEOUT_CYCLES-1, i.e. on the TIMEOUT_CYCLES-th stalled grant cycle.
//   sys_clk  in  clock
//   sys_rst  in  synchronous reset, active-high
//   clr      in  hold the count at zero (arbiter idle)
//   cnt_en   in  a granted cycle with the request still up and no ack
//   expire   out one-cycle abort request
module comm_arb_wdog #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic clr,
    input  logic cnt_en,
    output logic expire
);

    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (cnt_en) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire = cnt_en && (cnt_q == CntLast);

endmodule

// File: rtl/comm_ram_arbiter.sv
// Shares the RAM data port between the CPU data interface and the DMA master.
// CPU has priority; after STARVE_LIMIT consecutive CPU wins over a pending DMA request the
// DMA is forced through. One cycle of arbitration latency (the IDLE cycle); once granted, the
// owner's stb/we/addr/data are muxed straight onto the RAM port and ack/data straight back.
//
// Optional feature: define COMM_ARB_TIMEOUT_EN to add a watchdog (comm_arb_wdog) that aborts a
// grant after TIMEOUT_CYCLES cycles without ram_ack_i, answering the owner with TIMEOUT_DATA.
//
// Ports
//   sys_clk, sys_rst            clock, synchronous active-high reset
//   cpu_stb_i/ack_o/we_i/addr_i/data_i/data_o   CPU stb/ack requester
//   dma_stb_i/ack_o/we_i/addr_i/data_i/data_o   DMA stb/ack requester
//   ram_stb_o/ack_i/we_o/addr_o/data_o/data_i   RAM port
//   grant_o                     00 none, 01 CPU, 10 DMA
//   timeout_o                   one-cycle pulse on watchdog abort (0 without the watchdog)
module comm_ram_arbiter
    import comm_pkg::*;
#(
    parameter int unsigned ADDR_W         = 16,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned STARVE_LIMIT   = 4,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic              sys_clk,
    input  logic              sys_rst,

    input  logic              cpu_stb_i,
    output logic              cpu_ack_o,
    input  logic              cpu_we_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [DATA_W-1:0] cpu_data_i,
    output logic [DATA_W-1:0] cpu_data_o,

    input  logic              dma_stb_i,
    output logic              dma_ack_o,
    input  logic              dma_we_i,
    input  logic [ADDR_W-1:0] dma_addr_i,
    input  logic [DATA_W-1:0] dma_data_i,
    output logic [DATA_W-1:0] dma_data_o,

    output logic              ram_stb_o,
    input  logic              ram_ack_i,
    output logic              ram_we_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [DATA_W-1:0] ram_data_o,
    input  logic [DATA_W-1:0] ram_data_i,

    output logic [1:0]        grant_o,
    output logic              timeout_o
);

    localparam int unsigned StarveW = $clog2(STARVE_LIMIT + 1);
    localparam logic [StarveW-1:0] StarveMax = StarveW'(STARVE_LIMIT);

    state_e               state_q, state_d;
    logic [StarveW-1:0]   starve_q, starve_d;
    logic                 wdog_expire;

`ifdef COMM_ARB_TIMEOUT_EN
    logic owner_stb;
    logic wdog_clr;
    logic wdog_cnt_en;

    assign owner_stb   = (state_q == ST_GNT_CPU) ? cpu_stb_i :
                         (state_q == ST_GNT_DMA) ? dma_stb_i : 1'b0;
    // A dropped stb is an abort, not a stall, so it does not count toward the timeout.
    assign wdog_clr    = (state_q == ST_IDLE);
    assign wdog_cnt_en = owner_stb & ~ram_ack_i;

    comm_arb_wdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_wdog (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .clr     (wdog_clr),
        .cnt_en  (wdog_cnt_en),
        .expire  (wdog_expire)
    );
`else
    logic unused_timeout_cfg;

    assign wdog_expire        = 1'b0;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

    always_comb begin
        state_d    = state_q;
        starve_d   = starve_q;
        cpu_ack_o  = 1'b0;
        cpu_data_o = '0;
        dma_ack_o  = 1'b0;
        dma_data_o = '0;
        ram_stb_o  = 1'b0;
        ram_we_o   = 1'b0;
        ram_addr_o = '0;
        ram_data_o = '0;
        grant_o    = GNT_NONE;
        timeout_o  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (cpu_stb_i && dma_stb_i && (starve_q == StarveMax)) begin
                    state_d  = ST_GNT_DMA;
                    starve_d = '0;
                end else if (cpu_stb_i) begin
                    state_d = ST_GNT_CPU;
                    // Count CPU wins only while DMA is actually waiting.
                    if (!dma_stb_i) begin
                        starve_d = '0;
                    end else if (starve_q != StarveMax) begin
                        starve_d = starve_q + 1'b1;
                    end
                end else if (dma_stb_i) begin
                    state_d  = ST_GNT_DMA;
                    starve_d = '0;
                end
            end

            ST_GNT_CPU: begin
                grant_o    = GNT_CPU;
                ram_stb_o  = cpu_stb_i & ~wdog_expire;
                ram_we_o   = cpu_we_i;
                ram_addr_o = cpu_addr_i;
                ram_data_o = cpu_data_i;
                cpu_ack_o  = ram_ack_i | wdog_expire;
                cpu_data_o = wdog_expire ? DATA_W'(TIMEOUT_DATA) : ram_data_i;
                timeout_o  = wdog_expire;
                if (ram_ack_i || !cpu_stb_i || wdog_expire) begin
                    state_d = ST_IDLE;
                end
            end

            ST_GNT_DMA: begin
                grant_o    = GNT_DMA;
                ram_stb_o  = dma_stb_i & ~wdog_expire;
                ram_we_o   = dma_we_i;
                ram_addr_o = dma_addr_i;
                ram_data_o = dma_data_i;
                dma_ack_o  = ram_ack_i | wdog_expire;
                dma_data_o = wdog_expire ? DATA_W'(TIMEOUT_DATA) : ram_data_i;
                timeout_o  = wdog_expire;
                if (ram_ack_i || !dma_stb_i || wdog_expire) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q  <= ST_IDLE;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
        end
    end

endmodule
